matriz_transposta_seq: RTL and testbench

Sequential, parametrised successor to the combinational coprocessor transpose. It transposes a square matrix of runtime dimension n (1..MAX_DIM) held in the coprocessor's flat row-major bus, writing one result row per clock. It uses a start/busy/done handshake so the ULA controller can sequence it like the other multi-cycle operations. Elements outside the active n x n window are forced to zero.

---
 rtl/matriz_transposta_seq.sv | 176 +++++++++++++++++
 tb/tb_matriz_transposta_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/matriz_transposta_seq.sv
// -----------------------------------------------------------------------------
// matriz_transposta_seq
//
// Multi-cycle transpose of a square n x n matrix (n = 1..MAX_DIM, chosen at
// runtime) held in a flat row-major bus. One result row is written per clock.
// A start/busy/done handshake lets the ULA controller sequence it like the
// other multi-cycle operations. Result elements outside the active n x n
// window are zero.
//
// Element (r,c) sits at bits [ELEM_W*(c+MAX_DIM*r) +: ELEM_W] on both buses.
//
// Ports:
//   clk               rising-edge clock
//   reset             asynchronous, active-high reset
//   start             job request, sampled only in IDLE
//   size              runtime dimension n, sampled with start (0 -> 1,
//                     >MAX_DIM -> MAX_DIM)
//   mode              (TRANSP_ANTI_EN only) 0 = transpose, 1 = anti-transpose,
//                     sampled with start
//   matrizA           source matrix, flat row-major
//   matriz_resultante registered result, same layout
//   busy              high while rows are being written
//   done              one-cycle pulse, result complete
//
// Build option: define TRANSP_ANTI_EN to add the mode port and the
// anti-transpose result(r,c) = A(n-1-c, n-1-r). Undefined, the block always
// performs the plain transpose.
// -----------------------------------------------------------------------------
module matriz_transposta_seq #(
  parameter int MAX_DIM = 5,
  parameter int ELEM_W  = 8,
  parameter int DIM_W   = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [DIM_W-1:0]                  size,
`ifdef TRANSP_ANTI_EN
  input  logic                              mode,
`endif
  input  logic [ELEM_W*MAX_DIM*MAX_DIM-1:0] matrizA,
  output logic [ELEM_W*MAX_DIM*MAX_DIM-1:0] matriz_resultante,
  output logic                              busy,
  output logic                              done
);

  localparam int BUS_W = ELEM_W * MAX_DIM * MAX_DIM;
  localparam int ROW_W = ELEM_W * MAX_DIM;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROW,
    ST_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic [BUS_W-1:0]   r_a_cap;     // copy of matrizA taken at accept
  logic [BUS_W-1:0]   r_res;
  logic [DIM_W-1:0]   r_n;         // sanitised dimension for the current job
  logic [DIM_W-1:0]   r_row;
  logic [DIM_W-1:0]   w_n_sanit;
  logic [ROW_W-1:0]   w_row_data;
  logic               w_accept;
  logic               w_last_row;
`ifdef TRANSP_ANTI_EN
  logic               r_mode;
`endif

  assign matriz_resultante = r_res;

  // Clamp the requested size into 1..MAX_DIM.
  always_comb begin
    w_n_sanit = size;
    if (size == '0) begin
      w_n_sanit = DIM_W'(1);
    end else if (size > DIM_W'(MAX_DIM)) begin
      w_n_sanit = DIM_W'(MAX_DIM);
    end
  end

  assign w_last_row = (r_row == (r_n - DIM_W'(1)));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and handshake outputs.
  // NOTE: every signal driven here gets a default first; a path that leaves a
  // variable unassigned would infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = ST_ROW;
        end
      end
      ST_ROW: begin
        busy = 1'b1;
        if (w_last_row) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Result row r_row: column c takes A(c, r_row) (or A(n-1-c, n-1-r_row) in
  // anti mode) while c < n, zero beyond the window.
  always_comb begin
    int src_r;
    int src_c;
    w_row_data = '0;
    src_r      = 0;
    src_c      = 0;
    for (int c = 0; c < MAX_DIM; c++) begin
      src_r = c;
      src_c = int'(r_row);
`ifdef TRANSP_ANTI_EN
      if (r_mode) begin
        src_r = int'(r_n) - 1 - c;
        src_c = int'(r_n) - 1 - int'(r_row);
      end
`endif
      if (c < int'(r_n)) begin
        w_row_data[ELEM_W*c +: ELEM_W] = r_a_cap[ELEM_W*(src_c + MAX_DIM*src_r) +: ELEM_W];
      end
    end
  end

  // Datapath: capture at accept, one row per ROW cycle.
  // NOTE: the captured matrix is a register array that is cleared on reset on
  // purpose, so nothing from an abandoned job can leak into a later one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_cap <= '0;
      r_res   <= '0;
      r_n     <= '0;
      r_row   <= '0;
`ifdef TRANSP_ANTI_EN
      r_mode  <= 1'b0;
`endif
    end else if (w_accept) begin
      r_a_cap <= matrizA;
      r_n     <= w_n_sanit;
      r_res   <= '0;          // rows >= n stay zero for the whole job
      r_row   <= '0;
`ifdef TRANSP_ANTI_EN
      r_mode  <= mode;
`endif
    end else if (r_state == ST_ROW) begin
      r_res[ROW_W*int'(r_row) +: ROW_W] <= w_row_data;
      if (!w_last_row) begin
        r_row <= r_row + DIM_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_matriz_transposta_seq.sv
// -----------------------------------------------------------------------------
// tb_matriz_transposta_seq
//
// Directed bench for matriz_transposta_seq. Each job pushes its expected
// result into a scoreboard queue when it is launched; the entry is popped and
// compared when done is seen. Latency, busy length and the done pulse are
// checked alongside. With TRANSP_ANTI_EN defined the anti-transpose is
// exercised too.
// -----------------------------------------------------------------------------
module tb_matriz_transposta_seq;

  localparam int MAX_DIM = 5;
  localparam int ELEM_W  = 8;
  localparam int DIM_W   = 3;
  localparam int BUS_W   = ELEM_W * MAX_DIM * MAX_DIM;

  typedef logic [BUS_W-1:0] bus_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [DIM_W-1:0] size;
`ifdef TRANSP_ANTI_EN
  logic             mode;
`endif
  bus_t             matrizA;
  bus_t             matriz_resultante;
  logic             busy;
  logic             done;

  int   checks   = 0;
  int   failures = 0;
  bus_t q_exp[$];

  matriz_transposta_seq #(
    .MAX_DIM(MAX_DIM),
    .ELEM_W (ELEM_W),
    .DIM_W  (DIM_W)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .size             (size),
`ifdef TRANSP_ANTI_EN
    .mode             (mode),
`endif
    .matrizA          (matrizA),
    .matriz_resultante(matriz_resultante),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic bus_t make_a();
    bus_t a = '0;
    for (int r = 0; r < MAX_DIM; r++)
      for (int c = 0; c < MAX_DIM; c++)
        a[ELEM_W*(c + MAX_DIM*r) +: ELEM_W] = ELEM_W'(10*r + c);
    return a;
  endfunction

  function automatic int sanit(int sz);
    if (sz == 0) return 1;
    if (sz > MAX_DIM) return MAX_DIM;
    return sz;
  endfunction

  function automatic logic [ELEM_W-1:0] elem(bus_t m, int r, int c);
    return m[ELEM_W*(c + MAX_DIM*r) +: ELEM_W];
  endfunction

  // Reference: result(r,c) = A(c,r), or A(n-1-c, n-1-r) in anti mode.
  function automatic bus_t model(bus_t a, int n, bit md);
    bus_t m = '0;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        m[ELEM_W*(c + MAX_DIM*r) +: ELEM_W] = md ? elem(a, n-1-c, n-1-r) : elem(a, c, r);
    return m;
  endfunction

  task automatic check(input string tag, input bus_t obs, input bus_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one job, optionally poke a second start mid-job, wait for done
  // (bounded) and score it.
  task automatic run_job(input int sz, input bit md, input bus_t a,
                         input string tag, input bit interfere);
    int n;
    int lat;
    int busy_cnt;
    n = sanit(sz);
    q_exp.push_back(model(a, n, md));
    @(negedge clk);
    check({tag, ":done_low_before"}, bus_t'(done), bus_t'(0));
    start   = 1'b1;
    size    = DIM_W'(sz);
`ifdef TRANSP_ANTI_EN
    mode    = md;
`endif
    matrizA = a;
    @(negedge clk);
    start    = 1'b0;
    lat      = 1;
    busy_cnt = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (busy === 1'b1) busy_cnt++;
      if (interfere && lat == 2) begin
        start   = 1'b1;
        matrizA = ~a;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({tag, ":latency"},      bus_t'(lat),      bus_t'(n + 1));
    check({tag, ":busy_at_done"}, bus_t'(busy),     bus_t'(0));
    check({tag, ":busy_cycles"},  bus_t'(busy_cnt), bus_t'(n));
    if (q_exp.size() == 0) begin
      check({tag, ":scoreboard_empty"}, bus_t'(1), bus_t'(0));
    end else begin
      check({tag, ":result"}, matriz_resultante, q_exp.pop_front());
    end
  endtask

  initial begin
    bus_t a;
    bus_t b;
    int   extra_done;

    a       = make_a();
    reset   = 1'b1;
    start   = 1'b0;
    size    = '0;
`ifdef TRANSP_ANTI_EN
    mode    = 1'b0;
`endif
    matrizA = '0;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    check("reset:result", matriz_resultante, '0);
    check("reset:busy",   bus_t'(busy), bus_t'(0));
    check("reset:done",   bus_t'(done), bus_t'(0));
    reset = 1'b0;

    // 1. Full-size transpose.
    run_job(5, 1'b0, a, "t1_n5", 1'b0);
    check("t1:r0c4", bus_t'(elem(matriz_resultante, 0, 4)), bus_t'(40));
    check("t1:r4c0", bus_t'(elem(matriz_resultante, 4, 0)), bus_t'(4));

    // 2. Reduced size, window zeroing.
    run_job(3, 1'b0, a, "t2_n3", 1'b0);
    check("t2:r1c2", bus_t'(elem(matriz_resultante, 1, 2)), bus_t'(21));
    check("t2:r0c4", bus_t'(elem(matriz_resultante, 0, 4)), bus_t'(0));
    check("t2:r4c4", bus_t'(elem(matriz_resultante, 4, 4)), bus_t'(0));

    // 3. Clamping: 0 -> 1 (A(0,0)=0, so everything is zero), 7 -> 5.
    run_job(0, 1'b0, a, "t3_size0", 1'b0);
    check("t3:all_zero", matriz_resultante, '0);
    run_job(7, 1'b0, a, "t3_size7", 1'b0);
    check("t3:r0c4", bus_t'(elem(matriz_resultante, 0, 4)), bus_t'(40));

    // 4. Start while busy is ignored; exactly one done pulse.
    run_job(5, 1'b0, a, "t4_interfere", 1'b1);
    extra_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) extra_done++;
    end
    check("t4:no_extra_done", bus_t'(extra_done), bus_t'(0));

    // 4b. Back-to-back jobs: second start in the IDLE cycle right after done.
    b = '0;
    for (int i = 0; i < MAX_DIM*MAX_DIM; i++) b[ELEM_W*i +: ELEM_W] = ELEM_W'($urandom_range(1, 255));
    run_job(2, 1'b0, a, "t4_b2b_first", 1'b0);
    run_job(4, 1'b0, b, "t4_b2b_second", 1'b0);
    check("t4:b2b_r3c0", bus_t'(elem(matriz_resultante, 3, 0)), bus_t'(elem(b, 0, 3)));

    // 5. Asynchronous reset during the third ROW cycle.
    @(negedge clk);
    start   = 1'b1;
    size    = DIM_W'(5);
    matrizA = a;
    @(negedge clk);            // ROW cycle 1
    start = 1'b0;
    @(negedge clk);            // ROW cycle 2
    @(negedge clk);            // ROW cycle 3
    check("t5:partial_before_reset", bus_t'(busy), bus_t'(1));
    reset = 1'b1;
    #1;
    check("t5:result", matriz_resultante, '0);
    check("t5:busy",   bus_t'(busy), bus_t'(0));
    check("t5:done",   bus_t'(done), bus_t'(0));
    @(negedge clk);
    reset      = 1'b0;
    extra_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra_done++;
    end
    check("t5:no_activity_after", bus_t'(extra_done), bus_t'(0));
    run_job(5, 1'b0, a, "t5_after_reset", 1'b0);

`ifdef TRANSP_ANTI_EN
    // 6. Anti-transpose and return to plain mode.
    run_job(5, 1'b1, a, "t6_anti", 1'b0);
    check("t6:r0c0", bus_t'(elem(matriz_resultante, 0, 0)), bus_t'(44));
    check("t6:r0c4", bus_t'(elem(matriz_resultante, 0, 4)), bus_t'(4));
    check("t6:r4c0", bus_t'(elem(matriz_resultante, 4, 0)), bus_t'(40));
    check("t6:r1c3", bus_t'(elem(matriz_resultante, 1, 3)), bus_t'(13));
    run_job(5, 1'b0, a, "t6_plain", 1'b0);
    check("t6:plain_r0c4", bus_t'(elem(matriz_resultante, 0, 4)), bus_t'(40));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
